fadd_pipe: RTL
==============

// Module: fadd_pipe
// PURPOSE
//  Pipelined IEEE-754 single-precision adder, y = x1 + x2; the addition counterpart of the FPU subtractor.
//  Three register stages with valid/ready handshake on both sides; accepts one operation per cycle when not stalled.
//  Numerics are bit-identical to the FPU's combinational add/sub path: gradual underflow, round-to-nearest-even, overflow flag.
// PARAMETERS
//  TAG_W   4   width of opaque sideband tag carried with each operation (issue ID for the FPU dispatcher)
// PORTS
//  clk        in   1      clock, rising edge
//  rstn       in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      adder can accept this cycle
//  x1         in   32     operand 1 {sign,exp[7:0],man[22:0]}
//  x2         in   32     operand 2
//  in_tag     in   TAG_W  sideband tag
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  y          out  32     sum
//  ovf        out  1      overflow: both inputs finite (exp<255) and result rounded to exp 255
//  out_tag    out  TAG_W  tag of this result
// BEHAVIOUR
//  Reset (rstn=0, async): all stage valids=0; out_valid=0, y=0, ovf=0, out_tag=0; in-flight ops are discarded.
//  Handshake: transfer on valid&ready each side. stall = out_valid & ~out_ready; in_ready = ~stall.
//   On stall, every stage holds (no bubble collapse); otherwise all stages advance together.
//   out_valid/y/ovf/out_tag stay stable while stalled. Latency exactly 3 cycles from accept to out_valid when unstalled.
//  S1 (unpack/align): hidden bit=1 if exp!=0 else 0; effective exp = 1 for exp==0.
//   Larger operand by exponent; on equal exponent, by mantissa (x1 if m1>m2, else x2). Shift d = min(|e1-e2|,31).
//   Smaller mantissa shifted right by d into 56-bit field; bits below the guard+round positions OR into sticky.
//  S2 (add): same signs -> add, else larger minus smaller, 27-bit result {carry,hidden,23 man,guard,round}.
//   Carry out: if es+1==255 force exp 255, mantissa 0, flag overflow; else shift right 1, exp+1, lsb ORed into sticky.
//   Leading-zero count (0..26) of result computed here and registered.
//  S3 (normalize/round): if exp > lzc, shift left lzc, exp -= lzc; else shift left (exp-1), exp=0 (denormal).
//   RNE: round up if (G&R) | (G&~R&~sticky&lsb) | (G&~R&sticky&same-sign); mantissa rollover increments exp.
//   Result exactly zero -> y = {s1&s2, 31'b0} (x+(-x) = +0, -0+-0 = -0). Otherwise sign of larger operand.
//   Rounding to exp 255 -> mantissa 0 (Inf), ovf=1 provided e1<255 and e2<255.
//  Inputs with exp==255 (Inf/NaN): y unspecified, ovf=0; pipeline timing unaffected.
//  Simultaneous out-accept and in-accept in one cycle is the normal full-throughput case: no extra bubble.
//  in_valid while stalled: operands are not captured; source holds them (in_ready=0).
// TESTING
//  1) x1=0x3F800000, x2=0x3F800000, tag=3 -> after 3 cycles y=0x40000000, ovf=0, out_tag=3.
//  2) x1=0x3F800000, x2=0xBF800000 -> y=0x00000000; x1=x2=0x80000000 -> y=0x80000000.
//  3) x1=x2=0x7F7FFFFF -> y=0x7F800000, ovf=1; x1=0x7F800000, x2=0x3F800000 -> ovf=0.
//  4) Denormal/round: 0x00000001+0x00000001 -> 0x00000002; 0x3F800000+0x33800000 -> 0x3F800000 (tie to even);
//     0x3F800001+0x33800000 -> 0x3F800002.
//  5) Back-to-back 8 ops with out_ready low on cycles 4-6 -> in_ready low those cycles, no loss/duplication,
//     results and tags in order, y stable during stall.
//  6) rstn asserted with 3 ops in flight -> out_valid=0 immediately; after release, next op yields correct result
//     with no stale output.

Source files
------------

// File: rtl/fadd_pipe.sv
// fadd_pipe: three-stage pipelined IEEE-754 single-precision adder with valid/ready handshake
module fadd_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);
  function automatic logic [4:0] lzc(input logic [25:0] v);
    lzc = 5'd26;
    for (int i = 0; i < 26; i++)
      if (v[i]) lzc = 5'(25 - i);
  endfunction
  logic adv;
  assign adv = ~(out_valid & ~out_ready);
  assign in_ready = adv;
  // unpack and align the smaller operand; the low 30 bits of the field collapse into sticky
  logic [7:0] e1, e2, el, es, dd;
  logic [23:0] m1, m2, ml, ms;
  logic big1;
  logic [4:0] d;
  logic [55:0] al;
  assign e1 = (x1[30:23] == 8'd0) ? 8'd1 : x1[30:23];
  assign e2 = (x2[30:23] == 8'd0) ? 8'd1 : x2[30:23];
  assign m1 = {x1[30:23] != 8'd0, x1[22:0]};
  assign m2 = {x2[30:23] != 8'd0, x2[22:0]};
  assign big1 = (e1 > e2) | ((e1 == e2) & (m1 > m2));
  assign el = big1 ? e1 : e2;
  assign es = big1 ? e2 : e1;
  assign ml = big1 ? m1 : m2;
  assign ms = big1 ? m2 : m1;
  assign dd = el - es;
  assign d = (dd > 8'd31) ? 5'd31 : dd[4:0];
  assign al = {ms, 32'd0} >> d;
  logic a_v, a_sg, a_sm, a_z, a_f, a_st;
  logic [7:0] a_e;
  logic [23:0] a_ml;
  logic [25:0] a_ms;
  logic [TAG_W-1:0] a_t;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      a_v <= 1'b0; a_sg <= 1'b0; a_sm <= 1'b0; a_z <= 1'b0; a_f <= 1'b0; a_st <= 1'b0;
      a_e <= '0; a_ml <= '0; a_ms <= '0; a_t <= '0;
    end else if (adv) begin
      a_v <= in_valid;
      a_sg <= big1 ? x1[31] : x2[31];
      a_sm <= x1[31] == x2[31];
      a_z <= x1[31] & x2[31];
      a_f <= (x1[30:23] != 8'hff) & (x2[30:23] != 8'hff);
      a_st <= |al[29:0];
      a_e <= el;
      a_ml <= ml;
      a_ms <= al[55:30];
      a_t <= in_tag;
    end
  logic [26:0] sum;
  logic cy, icy, nst;
  logic [25:0] nsum;
  logic [7:0] ne2;
  assign sum = a_sm ? {1'b0, a_ml, 2'b0} + {1'b0, a_ms} : {1'b0, a_ml, 2'b0} - {1'b0, a_ms};
  assign cy = sum[26];
  assign icy = cy & (a_e == 8'd254);
  assign nsum = cy ? sum[26:1] : sum[25:0];
  assign ne2 = a_e + {7'd0, cy};
  assign nst = a_st | (cy & sum[0]);
  logic b_v, b_sg, b_sm, b_z, b_f, b_st, b_inf;
  logic [7:0] b_e;
  logic [25:0] b_n;
  logic [4:0] b_lz;
  logic [TAG_W-1:0] b_t;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      b_v <= 1'b0; b_sg <= 1'b0; b_sm <= 1'b0; b_z <= 1'b0; b_f <= 1'b0; b_st <= 1'b0; b_inf <= 1'b0;
      b_e <= '0; b_n <= '0; b_lz <= '0; b_t <= '0;
    end else if (adv) begin
      b_v <= a_v;
      b_sg <= a_sg;
      b_sm <= a_sm;
      b_z <= a_z;
      b_f <= a_f;
      b_st <= nst;
      b_inf <= icy;
      b_e <= ne2;
      b_n <= nsum;
      b_lz <= lzc(nsum);
      b_t <= a_t;
    end
  // normalize, then round on the packed {exp,man} so mantissa rollover carries into the exponent
  logic norm, g, r, lsb, up, zero;
  logic [4:0] sh;
  logic [25:0] nm;
  logic [7:0] ne3;
  logic [30:0] pk;
  logic [31:0] yn;
  logic ovn;
  assign norm = b_e > {3'd0, b_lz};
  assign sh = norm ? b_lz : b_e[4:0] - 5'd1;
  assign nm = b_n << sh;
  assign ne3 = nm[25] ? b_e - {3'd0, b_lz} : 8'd0;
  assign g = nm[1];
  assign r = nm[0];
  assign lsb = nm[2];
  assign up = (g & r) | (g & ~r & ~b_st & lsb) | (g & ~r & b_st & b_sm);
  assign pk = {ne3, nm[24:2]} + {30'd0, up};
  assign zero = b_n == 26'd0;
  assign yn = zero ? {b_z, 31'd0} : b_inf ? {b_sg, 8'hff, 23'd0} : {b_sg, pk};
  assign ovn = b_f & (b_inf | (~zero & (pk[30:23] == 8'hff)));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      out_valid <= 1'b0; y <= '0; ovf <= 1'b0; out_tag <= '0;
    end else if (adv) begin
      out_valid <= b_v;
      y <= yn;
      ovf <= ovn;
      out_tag <= b_t;
    end
endmodule
